cpu_control_unit: RTL and testbench

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

---
 rtl/cpu_control_unit_pkg.sv | 84 ++++++++
 rtl/control_decode.sv | 70 +++++++
 rtl/cpu_control_unit.sv | 182 ++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_unit_pkg.sv
// Shared definitions for the multi-cycle CPU control unit: FSM state
// encodings, opcode/func constants, controls bit positions and ALUOp codes.
// The optional handshake timeout is enabled with the MEM_TIMEOUT_EN macro.
package cpu_control_unit_pkg;

  // FSM states; the encoding is exported on the fsm_state debug port
  typedef enum logic [3:0] {
    ST_IF_REQ  = 4'd0,
    ST_IF_REL  = 4'd1,
    ST_ID      = 4'd2,
    ST_EX      = 4'd3,
    ST_MEM_RD  = 4'd4,
    ST_MEM_REL = 4'd5,
    ST_MEM_WR  = 4'd6,
    ST_WB      = 4'd7,
    ST_HALT    = 4'd8
  } state_t;

  // Primary opcodes, instruction[15:12]
  typedef enum logic [3:0] {
    OP_BNE   = 4'd0,
    OP_BEQ   = 4'd1,
    OP_BGZ   = 4'd2,
    OP_BLZ   = 4'd3,
    OP_ADI   = 4'd4,
    OP_ORI   = 4'd5,
    OP_LHI   = 4'd6,
    OP_LWD   = 4'd7,
    OP_SWD   = 4'd8,
    OP_JMP   = 4'd9,
    OP_JAL   = 4'd10,
    OP_RTYPE = 4'd15
  } opcode_t;

  // Function codes for opcode 15, instruction[5:0]
  typedef enum logic [5:0] {
    FN_ADD = 6'd0,
    FN_SUB = 6'd1,
    FN_AND = 6'd2,
    FN_ORR = 6'd3,
    FN_NOT = 6'd4,
    FN_TCP = 6'd5,
    FN_SHL = 6'd6,
    FN_SHR = 6'd7,
    FN_JPR = 6'd25,
    FN_JRL = 6'd26,
    FN_HLT = 6'd29
  } func_t;

  // ALU operation codes carried in controls[4:1]; R-type ops reuse func[3:0]
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_ORR = 4'd3,
    ALU_NOT = 4'd4,
    ALU_TCP = 4'd5,
    ALU_SHL = 4'd6,
    ALU_SHR = 4'd7,
    ALU_LHI = 4'd8,
    ALU_BNE = 4'd9,
    ALU_BEQ = 4'd10,
    ALU_BGZ = 4'd11,
    ALU_BLZ = 4'd12
  } alu_op_t;

  // controls = {Jump, Branch, MemtoReg, MemRead, MemWrite, RegDst, RegWrite, ALUOp[3:0], ALUSrc}
  localparam int CTL_W         = 12;
  localparam int CTL_JUMP      = 11;
  localparam int CTL_BRANCH    = 10;
  localparam int CTL_MEMTOREG  = 9;
  localparam int CTL_MEMREAD   = 8;
  localparam int CTL_MEMWRITE  = 7;
  localparam int CTL_REGDST    = 6;
  localparam int CTL_REGWRITE  = 5;
  localparam int CTL_ALUOP_LSB = 1;
  localparam int CTL_ALUSRC    = 0;

  // HLT is the only instruction that leaves the fetch/execute loop
  function automatic logic is_halt(input logic [3:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn == FN_HLT);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decoder: opcode/func -> controls vector.
// Anything not recognised decodes to all-zero controls and runs as a NOP.
// Phase gating of the write strobes is done by the FSM in cpu_control_unit.
module control_decode
  import cpu_control_unit_pkg::*;
(
  input  logic [3:0]       opcode,
  input  logic [5:0]       func,
  output logic [CTL_W-1:0] controls
);

  // Decode table, one arm per instruction group
  always_comb begin
    controls = '0;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
        controls[CTL_BRANCH] = 1'b1;
        controls[CTL_ALUOP_LSB +: 4] = ALU_BNE + {2'b00, opcode[1:0]};
      end
      OP_ADI: begin
        controls[CTL_ALUSRC]   = 1'b1;
        controls[CTL_REGWRITE] = 1'b1;
        controls[CTL_ALUOP_LSB +: 4] = ALU_ADD;
      end
      OP_ORI: begin
        controls[CTL_ALUSRC]   = 1'b1;
        controls[CTL_REGWRITE] = 1'b1;
        controls[CTL_ALUOP_LSB +: 4] = ALU_ORR;
      end
      OP_LHI: begin
        controls[CTL_ALUSRC]   = 1'b1;
        controls[CTL_REGWRITE] = 1'b1;
        controls[CTL_ALUOP_LSB +: 4] = ALU_LHI;
      end
      OP_LWD: begin
        controls[CTL_MEMREAD]  = 1'b1;
        controls[CTL_MEMTOREG] = 1'b1;
        controls[CTL_ALUSRC]   = 1'b1;
        controls[CTL_REGWRITE] = 1'b1;
        controls[CTL_ALUOP_LSB +: 4] = ALU_ADD;
      end
      OP_SWD: begin
        controls[CTL_MEMWRITE] = 1'b1;
        controls[CTL_ALUSRC]   = 1'b1;
        controls[CTL_ALUOP_LSB +: 4] = ALU_ADD;
      end
      OP_JMP: begin
        controls[CTL_JUMP] = 1'b1;
      end
      OP_JAL: begin
        controls[CTL_JUMP]     = 1'b1;
        controls[CTL_REGWRITE] = 1'b1;
      end
      OP_RTYPE: begin
        if (func <= FN_SHR) begin
          controls[CTL_REGDST]   = 1'b1;
          controls[CTL_REGWRITE] = 1'b1;
          controls[CTL_ALUOP_LSB +: 4] = func[3:0];
        end else if (func == FN_JPR) begin
          controls[CTL_JUMP] = 1'b1;
        end else if (func == FN_JRL) begin
          controls[CTL_JUMP]     = 1'b1;
          controls[CTL_REGWRITE] = 1'b1;
        end
      end
      default: controls = '0;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle CPU control FSM: fetch handshake, decode, execute, optional
// memory read/write handshake, write-back, retired-instruction counter and
// halt. Define MEM_TIMEOUT_EN to add the 8-bit handshake watchdog and the
// sticky mem_err output.
//
// Memory handshake: readM (or writeM) is a request that stays high until the
// memory answers with inputReady (or ackOutput) sampled high on a clk edge;
// the request drops on that same edge. After a read the FSM waits for
// inputReady to fall before moving on, so a new readM never rises while
// inputReady is still high. Only the answer matching the current state is
// looked at; the other input is ignored.
module cpu_control_unit
  import cpu_control_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       opcode,
  input  logic [5:0]       func,
  input  logic             inputReady,
  input  logic             ackOutput,
  output logic             readM,
  output logic             writeM,
  output logic             ir_load,
  output logic             mdr_load,
  output logic             pc_write,
  output logic [CTL_W-1:0] controls,
  output logic [15:0]      num_inst,
  output logic             halted,
`ifdef MEM_TIMEOUT_EN
  output logic             mem_err,
`endif
  output state_t           fsm_state
);

  state_t           state;
  logic [CTL_W-1:0] dec_controls;

  control_decode u_decode (
    .opcode   (opcode),
    .func     (func),
    .controls (dec_controls)
  );

  assign fsm_state = state;

  // Decoded controls are visible from ID through WB; RegWrite is a WB-only
  // strobe and MemWrite is only high while the write request is outstanding
  always_comb begin
    controls = '0;
    case (state)
      ST_ID, ST_EX, ST_MEM_RD, ST_MEM_REL, ST_MEM_WR, ST_WB: controls = dec_controls;
      default: controls = '0;
    endcase
    if (state != ST_WB)     controls[CTL_REGWRITE] = 1'b0;
    if (state != ST_MEM_WR) controls[CTL_MEMWRITE] = 1'b0;
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  logic       in_wait;
  logic       wait_done;

  // Which states are waiting on memory, and whether the wait ends this cycle
  always_comb begin
    in_wait      = (state == ST_IF_REQ) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
    wait_cnt_nxt = wait_cnt + 8'd1;
    case (state)
      ST_IF_REQ, ST_MEM_RD: wait_done = readM && inputReady;
      ST_MEM_WR:            wait_done = ackOutput;
      default:              wait_done = 1'b0;
    endcase
  end
`endif

  // Main FSM with registered handshake requests, pulses and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IF_REQ;
      readM    <= 1'b0;
      writeM   <= 1'b0;
      ir_load  <= 1'b0;
      mdr_load <= 1'b0;
      pc_write <= 1'b0;
      num_inst <= 16'd0;
      halted   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      mem_err  <= 1'b0;
      wait_cnt <= 8'd0;
`endif
    end else begin
      ir_load  <= 1'b0;
      mdr_load <= 1'b0;
      pc_write <= 1'b0;
      case (state)
        ST_IF_REQ: begin
          if (readM && inputReady) begin
            readM   <= 1'b0;
            ir_load <= 1'b1;
            state   <= ST_IF_REL;
          end else if (!inputReady) begin
            readM <= 1'b1;
          end
        end
        ST_IF_REL: begin
          if (!inputReady) state <= ST_ID;
        end
        ST_ID: begin
          if (is_halt(opcode, func)) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            state <= ST_EX;
          end
        end
        ST_EX: begin
          case (opcode)
            OP_LWD: state <= ST_MEM_RD;
            OP_SWD: begin
              writeM <= 1'b1;
              state  <= ST_MEM_WR;
            end
            default: begin
              pc_write <= 1'b1;
              state    <= ST_WB;
            end
          endcase
        end
        ST_MEM_RD: begin
          if (readM && inputReady) begin
            readM    <= 1'b0;
            mdr_load <= 1'b1;
            state    <= ST_MEM_REL;
          end else if (!inputReady) begin
            readM <= 1'b1;
          end
        end
        ST_MEM_REL: begin
          if (!inputReady) begin
            pc_write <= 1'b1;
            state    <= ST_WB;
          end
        end
        ST_MEM_WR: begin
          if (ackOutput) begin
            writeM   <= 1'b0;
            pc_write <= 1'b1;
            state    <= ST_WB;
          end
        end
        ST_WB: begin
          num_inst <= num_inst + 16'd1;
          state    <= ST_IF_REQ;
        end
        ST_HALT: begin
          readM  <= 1'b0;
          writeM <= 1'b0;
        end
        default: state <= ST_IF_REQ;
      endcase
`ifdef MEM_TIMEOUT_EN
      // Watchdog: trips on the edge where the wait count would reach 255;
      // a completed handshake on the same edge takes priority
      if (!in_wait || wait_done) begin
        wait_cnt <= 8'd0;
      end else if (wait_cnt_nxt == 8'hFF) begin
        wait_cnt <= 8'd0;
        mem_err  <= 1'b1;
        halted   <= 1'b1;
        readM    <= 1'b0;
        writeM   <= 1'b0;
        ir_load  <= 1'b0;
        mdr_load <= 1'b0;
        state    <= ST_HALT;
      end else begin
        wait_cnt <= wait_cnt_nxt;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit. Define MEM_TIMEOUT_EN for both the
// DUT and this bench to include the handshake watchdog scenario.
module tb_cpu_control_unit;
  import cpu_control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic [5:0]  func = 6'd0;
  logic        inputReady = 1'b0;
  logic        ackOutput = 1'b0;
  logic        readM, writeM, ir_load, mdr_load, pc_write, halted;
  logic [11:0] controls;
  logic [15:0] num_inst;
  state_t      fsm_state;
`ifdef MEM_TIMEOUT_EN
  logic        mem_err;
`endif

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_inst = 16'd0;

  // clock/reset block
  always #5 clk = ~clk;

  cpu_control_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .func       (func),
    .inputReady (inputReady),
    .ackOutput  (ackOutput),
    .readM      (readM),
    .writeM     (writeM),
    .ir_load    (ir_load),
    .mdr_load   (mdr_load),
    .pc_write   (pc_write),
    .controls   (controls),
    .num_inst   (num_inst),
    .halted     (halted),
`ifdef MEM_TIMEOUT_EN
    .mem_err    (mem_err),
`endif
    .fsm_state  (fsm_state)
  );

  // event counters sampled on the falling edge
  int   rd_rise = 0, ir_cnt = 0, mdr_cnt = 0, pcw_cnt = 0, wr_cyc = 0, rw_cnt = 0;
  logic rd_q = 1'b0;
  always @(negedge clk) begin
    if (readM && !rd_q) rd_rise <= rd_rise + 1;
    rd_q <= readM;
    if (ir_load)     ir_cnt  <= ir_cnt + 1;
    if (mdr_load)    mdr_cnt <= mdr_cnt + 1;
    if (pc_write)    pcw_cnt <= pcw_cnt + 1;
    if (writeM)      wr_cyc  <= wr_cyc + 1;
    if (controls[5]) rw_cnt  <= rw_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (readM) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // memory read: answer one cycle after readM is seen, drop one cycle later
  task automatic serve_read(input logic load_ir, input logic [3:0] op, input logic [5:0] fn,
                            input string tag);
    bit ok;
    wait_read(ok);
    check_eq({tag, "_readM_seen"}, 32'(ok), 32'd1);
    if (!ok) return;
    @(posedge clk); #1;
    inputReady = 1'b1;
    if (load_ir) begin
      opcode = op;
      func   = fn;
    end
    @(posedge clk); #1;
    inputReady = 1'b0;
  endtask

  // memory write: ack so that writeM is high exactly 5 cycles; inputReady
  // is raised alongside ack and must be ignored
  task automatic serve_write(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (writeM) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_writeM_seen"}, 32'(ok), 32'd1);
    if (!ok) return;
    check_eq({tag, "_memwr_ctrl"}, 32'(controls), 32'h081);
    repeat (4) @(posedge clk);
    #1;
    ackOutput  = 1'b1;
    inputReady = 1'b1;
    @(posedge clk); #1;
    ackOutput  = 1'b0;
    inputReady = 1'b0;
  endtask

  // driver: fetch + execute one instruction; kind 0 plain, 1 LWD, 2 SWD
  task automatic run_instr(input logic [3:0] op, input logic [5:0] fn, input int kind,
                           input logic [11:0] exp_id, input logic [11:0] exp_wb,
                           input int exp_rw, input string tag);
    int rd0, ir0, mdr0, pcw0, wr0, rw0;
    bit ok;
    rd0 = rd_rise; ir0 = ir_cnt; mdr0 = mdr_cnt; pcw0 = pcw_cnt; wr0 = wr_cyc; rw0 = rw_cnt;
    serve_read(1'b1, op, fn, tag);
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, "_id_ctrl"}, 32'(controls), 32'(exp_id));
    if (kind == 1) serve_read(1'b0, op, fn, {tag, "_data"});
    else if (kind == 2) serve_write(tag);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pc_write) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_wb_reached"}, 32'(ok), 32'd1);
    check_eq({tag, "_wb_ctrl"}, 32'(controls), 32'(exp_wb));
    exp_inst = exp_inst + 16'd1;
    @(negedge clk);
    check_eq({tag, "_num_inst"}, 32'(num_inst), 32'(exp_inst));
    @(posedge clk); #1;
    check_eq({tag, "_readM_rises"}, 32'(rd_rise - rd0), (kind == 1) ? 32'd2 : 32'd1);
    check_eq({tag, "_ir_pulses"}, 32'(ir_cnt - ir0), 32'd1);
    check_eq({tag, "_mdr_pulses"}, 32'(mdr_cnt - mdr0), (kind == 1) ? 32'd1 : 32'd0);
    check_eq({tag, "_pcw_pulses"}, 32'(pcw_cnt - pcw0), 32'd1);
    check_eq({tag, "_writeM_cycles"}, 32'(wr_cyc - wr0), (kind == 2) ? 32'd5 : 32'd0);
    check_eq({tag, "_regwrite_cycles"}, 32'(rw_cnt - rw0), 32'(exp_rw));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "bench timed out");
  end

  initial begin
    bit ok;
    int pcw0, rd_hi, n_err;

    // reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_readM", 32'(readM), 32'd0);
    check_eq("rst_writeM", 32'(writeM), 32'd0);
    check_eq("rst_pulses", 32'({ir_load, mdr_load, pc_write}), 32'd0);
    check_eq("rst_controls", 32'(controls), 32'd0);
    check_eq("rst_num_inst", 32'(num_inst), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_state", 32'(fsm_state), 32'(ST_IF_REQ));
`ifdef MEM_TIMEOUT_EN
    check_eq("rst_mem_err", 32'(mem_err), 32'd0);
`endif

    // ADI with exact cycle timing from reset release
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("adi_readM_before_edge", 32'(readM), 32'd0);
    @(negedge clk);                       // cycle 1
    check_eq("adi_readM_cycle1", 32'(readM), 32'd1);
    @(posedge clk); #1;                   // cycle 2
    inputReady = 1'b1;
    opcode = 4'd4;
    func   = 6'd0;
    @(posedge clk); #1;                   // cycle 3
    inputReady = 1'b0;
    check_eq("adi_ir_load", 32'(ir_load), 32'd1);
    check_eq("adi_readM_released", 32'(readM), 32'd0);
    @(negedge clk);
    @(negedge clk);                       // cycle 4 (ID)
    check_eq("adi_id_ctrl", 32'(controls), 32'h001);
    @(negedge clk);                       // cycle 5 (EX)
    check_eq("adi_pcw_cycle5", 32'(pc_write), 32'd0);
    @(negedge clk);                       // cycle 6 (WB)
    check_eq("adi_pcw_cycle6", 32'(pc_write), 32'd1);
    check_eq("adi_wb_ctrl", 32'(controls), 32'h021);
    @(negedge clk);                       // cycle 7
    exp_inst = 16'd1;
    check_eq("adi_num_inst", 32'(num_inst), 32'(exp_inst));
    check_eq("adi_pcw_cycle7", 32'(pc_write), 32'd0);
    @(posedge clk); #1;

    // instruction mix
    run_instr(4'd7,  6'd0,  1, 12'h301, 12'h321, 1, "lwd");
    run_instr(4'd8,  6'd0,  2, 12'h001, 12'h001, 0, "swd");
    run_instr(4'd5,  6'd0,  0, 12'h007, 12'h027, 1, "ori");
    run_instr(4'd6,  6'd0,  0, 12'h011, 12'h031, 1, "lhi");
    run_instr(4'd15, 6'd6,  0, 12'h04C, 12'h06C, 1, "shl");
    run_instr(4'd1,  6'd0,  0, 12'h414, 12'h414, 0, "beq");
    run_instr(4'd9,  6'd0,  0, 12'h800, 12'h800, 0, "jmp");
    run_instr(4'd10, 6'd0,  0, 12'h800, 12'h820, 1, "jal");
    run_instr(4'd15, 6'd25, 0, 12'h800, 12'h800, 0, "jpr");
    run_instr(4'd15, 6'd26, 0, 12'h800, 12'h820, 1, "jrl");
    run_instr(4'd11, 6'd0,  0, 12'h000, 12'h000, 0, "nop_op11");
    run_instr(4'd15, 6'd40, 0, 12'h000, 12'h000, 0, "nop_fn40");

    // asynchronous reset while readM is high
    wait_read(ok);
    check_eq("arst_readM_high", 32'(ok), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_readM_dropped", 32'(readM), 32'd0);
    check_eq("arst_state", 32'(fsm_state), 32'(ST_IF_REQ));
    check_eq("arst_num_inst", 32'(num_inst), 32'd0);
    exp_inst = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("arst_no_pulse", 32'({ir_load, mdr_load, pc_write}), 32'd0);
    reset_n = 1'b1;
    #1;
    run_instr(4'd4, 6'd0, 0, 12'h001, 12'h021, 1, "adi_after_rst");

    // HLT
    pcw0 = pcw_cnt;
    serve_read(1'b1, 4'd15, 6'd29, "hlt");
    @(negedge clk);
    @(negedge clk);
    check_eq("hlt_id_ctrl", 32'(controls), 32'd0);
    @(negedge clk);
    check_eq("hlt_halted", 32'(halted), 32'd1);
    check_eq("hlt_state", 32'(fsm_state), 32'(ST_HALT));
    rd_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (readM || writeM) rd_hi++;
    end
    check_eq("hlt_no_requests", 32'(rd_hi), 32'd0);
    check_eq("hlt_num_inst", 32'(num_inst), 32'(exp_inst));
    check_eq("hlt_controls", 32'(controls), 32'd0);
    check_eq("hlt_no_pcw", 32'(pcw_cnt - pcw0), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // fetch never answered: watchdog trips after 255 cycles in IF_REQ
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n_err = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (mem_err) begin
        n_err = i;
        break;
      end
    end
    check_eq("tmo_cycles", 32'(n_err), 32'd255);
    check_eq("tmo_readM", 32'(readM), 32'd0);
    check_eq("tmo_halted", 32'(halted), 32'd1);
    check_eq("tmo_state", 32'(fsm_state), 32'(ST_HALT));
    repeat (3) @(negedge clk);
    check_eq("tmo_sticky", 32'(mem_err), 32'd1);
`else
    n_err = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
